// File: rtl/p23_timer_pkg.sv
// Shared definitions for the down-counting timer.
//   state_t          : FSM encoding (S_IDLE, S_RUN)
//   DEF_WIDTH        : default width of the count / reload registers
//   DEF_PRESC_WIDTH  : default width of the prescaler divide value
package p23_timer_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_PRESC_WIDTH = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/p23_down_timer_if.sv
// Control/status bundle of the down timer.
//   master : drives load/load_val/presc_val/start/stop/periodic/irq_clr,
//            observes count/running/expired/irq
//   slave  : the timer itself
interface p23_down_timer_if
    import p23_timer_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int PRESC_WIDTH = DEF_PRESC_WIDTH
);

    logic                   load;
    logic [WIDTH-1:0]       load_val;
    logic [PRESC_WIDTH-1:0] presc_val;
    logic                   start;
    logic                   stop;
    logic                   periodic;
    logic                   irq_clr;
    logic [WIDTH-1:0]       count;
    logic                   running;
    logic                   expired;
    logic                   irq;

    modport master (
        output load, load_val, presc_val, start, stop, periodic, irq_clr,
        input  count, running, expired, irq
    );

    modport slave (
        input  load, load_val, presc_val, start, stop, periodic, irq_clr,
        output count, running, expired, irq
    );

endinterface

// File: rtl/p23_prescaler.sv
// Prescaler for the down timer: produces one tick every presc_val+1 enabled cycles.
//   clk, resetn : clock, asynchronous active-low reset
//   enable      : counting allowed (timer in RUN); no ticks while low
//   restart     : reload the divider from presc_val (start or load)
//   presc_val   : divide value, sampled whenever the divider reloads
//   tick        : combinational, high in the enabled cycle where the divider is 0
module p23_prescaler #(
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic                   restart,
    input  logic [PRESC_WIDTH-1:0] presc_val,
    output logic                   tick
);

    logic [PRESC_WIDTH-1:0] presc_cnt_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_cnt_reg <= '0;
        end else if (restart) begin
            presc_cnt_reg <= presc_val;
        end else if (enable) begin
            if (presc_cnt_reg == '0) begin
                presc_cnt_reg <= presc_val;
            end else begin
                presc_cnt_reg <= presc_cnt_reg - 1'b1;
            end
        end
    end

    assign tick = enable && (presc_cnt_reg == '0);

endmodule

// File: rtl/p23_down_timer.sv
// Programmable down-counting timer with prescaler, one-shot/periodic modes
// and a sticky interrupt flag.
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : load/load_val/presc_val/start/stop/periodic/irq_clr in,
//                 count/running/expired/irq out (all registered)
// Expiry period is (load_val+1)*(presc_val+1) cycles.
module p23_down_timer
    import p23_timer_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int PRESC_WIDTH = DEF_PRESC_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    p23_down_timer_if.slave  bus
);

    state_t           state_reg;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] reload_reg;
    logic             expired_reg;
    logic             irq_reg;

    logic start_accept;
    logic tick;
    logic count_tick;
    logic expiry;

    // start is only honoured from IDLE, and a simultaneous stop cancels it.
    assign start_accept = (state_reg == S_IDLE) && bus.start && !bus.stop;

    p23_prescaler #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_prescaler (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (state_reg == S_RUN),
        .restart   (bus.load || start_accept),
        .presc_val (bus.presc_val),
        .tick      (tick)
    );

    // A tick is swallowed by a stop (leaving RUN) or a load (new value wins).
    assign count_tick = tick && !bus.stop && !bus.load;
    assign expiry     = count_tick && (count_reg == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= S_IDLE;
            count_reg   <= '0;
            reload_reg  <= '0;
            expired_reg <= 1'b0;
            irq_reg     <= 1'b0;
        end else begin
            expired_reg <= expiry;

            if (bus.load) begin
                count_reg  <= bus.load_val;
                reload_reg <= bus.load_val;
            end

            case (state_reg)
                S_IDLE: begin
                    if (start_accept) begin
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        state_reg <= S_IDLE;
                    end else if (count_tick) begin
                        if (count_reg != '0) begin
                            count_reg <= count_reg - 1'b1;
                        end else if (bus.periodic) begin
                            count_reg <= reload_reg;
                        end else begin
                            // one-shot: count rests at zero
                            state_reg <= S_IDLE;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            // set has priority over clear
            if (expiry) begin
                irq_reg <= 1'b1;
            end else if (bus.irq_clr) begin
                irq_reg <= 1'b0;
            end
        end
    end

    assign bus.count   = count_reg;
    assign bus.running = (state_reg == S_RUN);
    assign bus.expired = expired_reg;
    assign bus.irq     = irq_reg;

endmodule

// File: tb/tb_p23_down_timer.sv
// Self-checking bench for p23_down_timer: directed scenarios followed by a
// randomized phase, all compared against an absolute-time reference model.
module tb_p23_down_timer;
    import p23_timer_pkg::*;

    localparam int W  = 32;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    p23_down_timer_if #(.WIDTH(W), .PRESC_WIDTH(PW)) bus ();

    p23_down_timer #(.WIDTH(W), .PRESC_WIDTH(PW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: ticks are scheduled at absolute edge numbers.
    longint         cyc;
    longint         m_next_tick;
    bit             m_run;
    bit             m_exp;
    bit             m_irq;
    logic [W-1:0]   m_count;
    logic [W-1:0]   m_reload;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_exp = 0; m_irq = 0; m_count = '0; m_reload = '0;
        m_next_tick = 0;
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_edge();
        longint       n;
        bit           tk, sa, run, e;
        logic [W-1:0] c, r;
        n   = cyc + 1;
        tk  = m_run && (n == m_next_tick);
        sa  = !m_run && bus.start && !bus.stop;
        c   = m_count;
        r   = m_reload;
        run = m_run;
        e   = 0;
        if (bus.load) begin
            c = bus.load_val;
            r = bus.load_val;
        end
        if (m_run && bus.stop) begin
            run = 0;
        end else if (sa) begin
            run = 1;
        end else if (tk && !bus.load) begin
            if (m_count != 0) begin
                c = m_count - 1;
            end else begin
                e = 1;
                if (bus.periodic) c = m_reload;
                else run = 0;
            end
        end
        if (bus.load || sa || tk) m_next_tick = n + longint'(bus.presc_val) + 1;
        if (e) m_irq = 1;
        else if (bus.irq_clr) m_irq = 0;
        m_exp = e; m_run = run; m_count = c; m_reload = r; cyc = n;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".count"},   bus.count,           m_count);
        check({tag, ".running"}, W'(bus.running),     W'(m_run));
        check({tag, ".expired"}, W'(bus.expired),     W'(m_exp));
        check({tag, ".irq"},     W'(bus.irq),         W'(m_irq));
    endtask

    // One clock: model, edge, sample 1 ns later, compare, drop the pulses.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
        $display("step %-10s t=%0t count=%0d running=%0b expired=%0b irq=%0b",
                 tag, $time, bus.count, bus.running, bus.expired, bus.irq);
        bus.load = 0; bus.start = 0; bus.stop = 0; bus.irq_clr = 0;
    endtask

    int n_exp;
    int last_exp;
    bit all_run;

    initial begin
        bus.load = 0; bus.load_val = '0; bus.presc_val = '0; bus.start = 0;
        bus.stop = 0; bus.periodic = 0; bus.irq_clr = 0;
        resetn = 0;
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        resetn = 1;

        // One-shot, presc 0, load 3 with start
        bus.presc_val = 0; bus.load_val = 3; bus.load = 1; bus.start = 1; bus.periodic = 0;
        step("os_E0");
        check("os_E0_cnt", bus.count, 3);
        step("os_E1"); step("os_E2"); step("os_E3");
        check("os_E3_cnt", bus.count, 0);
        step("os_E4");
        check("os_exp", W'(bus.expired), 1);
        check("os_irq", W'(bus.irq), 1);
        check("os_run", W'(bus.running), 0);
        step("os_E5");
        check("os_exp_once", W'(bus.expired), 0);

        // IRQ: clear colliding with expiry keeps it set
        bus.irq_clr = 1; step("irq_pre");
        check("irq_pre", W'(bus.irq), 0);
        bus.load_val = 1; bus.load = 1; bus.start = 1;
        step("irq_E0"); step("irq_E1");
        bus.irq_clr = 1; step("irq_E2");
        check("irq_setwins", W'(bus.irq), 1);
        bus.irq_clr = 1; step("irq_clr");
        check("irq_cleared", W'(bus.irq), 0);

        // Periodic, presc 1, load 2: expiry every 6 cycles
        bus.presc_val = 1; bus.load_val = 2; bus.load = 1; bus.start = 1; bus.periodic = 1;
        step("per_E0");
        n_exp = 0; last_exp = -1; all_run = 1;
        for (int i = 1; i <= 18; i++) begin
            step("per");
            if (!bus.running) all_run = 0;
            if (bus.expired) begin
                if (last_exp >= 0) check("per_gap", W'(i - last_exp), 6);
                check("per_reload", bus.count, 2);
                last_exp = i;
                n_exp++;
            end
        end
        check("per_nexp", W'(n_exp), 3);
        check("per_running", W'(all_run), 1);
        bus.stop = 1; step("per_stop");

        // Load coinciding with the terminal tick: load wins
        bus.periodic = 0; bus.presc_val = 2; bus.load_val = 1; bus.load = 1; bus.start = 1;
        step("ld_E0");
        for (int i = 1; i <= 5; i++) step("ld_run");
        check("ld_at0", bus.count, 0);
        bus.load_val = 7; bus.load = 1;
        step("ld_E6");
        check("ld_cnt", bus.count, 7);
        check("ld_noexp", W'(bus.expired), 0);
        step("ld_E7"); step("ld_E8");
        check("ld_hold", bus.count, 7);
        step("ld_E9");
        check("ld_tick", bus.count, 6);
        bus.stop = 1; step("ld_stop");

        // start+stop together in IDLE, then stop/resume
        bus.start = 1; bus.stop = 1; step("ss_idle");
        check("ss_idle_run", W'(bus.running), 0);
        bus.presc_val = 0; bus.load_val = 6; bus.load = 1; bus.start = 1;
        step("sr_E0"); step("sr_E1"); step("sr_E2");
        bus.stop = 1; step("sr_stop");
        check("sr_held", bus.count, 4);
        check("sr_idle", W'(bus.running), 0);
        step("sr_idle1"); step("sr_idle2");
        check("sr_still", bus.count, 4);
        bus.start = 1; step("sr_resume");
        check("sr_resume_cnt", bus.count, 4);
        step("sr_after");
        check("sr_dec", bus.count, 3);

        // Reset mid-RUN at count 5, no clock edge needed
        bus.load_val = 9; bus.load = 1; bus.start = 1;
        step("rs_E0");
        for (int i = 1; i <= 4; i++) step("rs_run");
        check("rs_pre", bus.count, 5);
        #3;
        resetn = 0;
        #1;
        model_reset();
        check("rs_cnt", bus.count, 0);
        check("rs_run", W'(bus.running), 0);
        check("rs_irq", W'(bus.irq), 0);
        check("rs_exp", W'(bus.expired), 0);
        @(posedge clk); @(posedge clk);
        #1;
        resetn = 1;

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            bus.load      = ($urandom_range(0, 15) == 0);
            bus.load_val  = W'($urandom_range(0, 6));
            bus.start     = ($urandom_range(0, 7) == 0);
            bus.stop      = ($urandom_range(0, 31) == 0);
            bus.irq_clr   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) bus.periodic  = $urandom_range(0, 1);
            if ($urandom_range(0, 31) == 0) bus.presc_val = PW'($urandom_range(0, 3));
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
